// File: rtl/layer3_parity_bank_buffer.sv
// Frame buffer ahead of the layer-3 2x2 max-pool: pixels land in four parity banks so one
// pooled coordinate reads a whole window in one cycle. Optional macro: LAYER3_BUF_WRITE_TRACK_EN.
module layer3_parity_bank_buffer #(
    parameter int DATA_W  = 128,
    parameter int FRAME_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [15:0]       wr_row,
    input  logic [15:0]       wr_col,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              read_pixel_signal,
    input  logic [15:0]       read_row_addr,
    input  logic [15:0]       read_col_addr,
    output logic [DATA_W-1:0] input_data_even_even,
    output logic [DATA_W-1:0] input_data_even_odd,
    output logic [DATA_W-1:0] input_data_odd_even,
    output logic [DATA_W-1:0] input_data_odd_odd,
    output logic              pixel_store_done,
    input  logic              layer3_calculation_done,
    output logic              state_dbg
);

    localparam int HALF  = FRAME_W / 2;
    localparam int DEPTH = HALF * HALF;
    localparam int TOTAL = FRAME_W * FRAME_W;
    localparam int CNT_W = $clog2(TOTAL) + 1;
    localparam int ENT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] FRAME16 = 16'(FRAME_W);
    localparam logic [15:0] HALF16  = 16'(HALF);

    typedef enum logic {FILL = 1'b0, READY = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wr_count;
    logic               done_q;
    logic               accept, dup, count_inc, complete, release_ev;
    logic [1:0]         wr_bank;
    logic [ENT_W-1:0]   wr_ent, rd_ent;
    logic               rd_ok;
    logic [DATA_W-1:0]  bank [4][DEPTH];

    // Write side: strict strobe, a write is taken only when wr_en and wr_ready coincide in range.
    assign wr_ready   = (state_q == FILL);
    assign accept     = wr_ready && wr_en && (wr_row < FRAME16) && (wr_col < FRAME16);
    assign wr_bank    = {wr_row[0], wr_col[0]};
    assign wr_ent     = ENT_W'((32'(wr_row) >> 1) * HALF + (32'(wr_col) >> 1));
    assign release_ev = (state_q == READY) && layer3_calculation_done;

`ifdef LAYER3_BUF_WRITE_TRACK_EN
    localparam int PIX_W = $clog2(TOTAL);
    logic [TOTAL-1:0] valid_q;
    logic [PIX_W-1:0] pix_idx;

    assign pix_idx = PIX_W'(32'(wr_row) * FRAME_W + 32'(wr_col));
    // Counting only first writes of each pixel makes count==TOTAL equivalent to "all pixels valid".
    assign dup     = valid_q[pix_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (release_ev) begin
            valid_q <= '0;
        end else if (accept) begin
            valid_q[pix_idx] <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign count_inc = accept && !dup;
    assign complete  = count_inc && (wr_count == CNT_W'(TOTAL - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (complete)                state_d = READY;
            READY:   if (layer3_calculation_done) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            wr_count <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= complete;
            if (complete) begin
                wr_count <= '0;
            end else if (count_inc) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bank[wr_bank][wr_ent] <= wr_data;
        end
    end

    // Read side is purely combinational; a same-cycle write is not visible until the next cycle.
    assign rd_ok  = read_pixel_signal && (read_row_addr < HALF16) && (read_col_addr < HALF16);
    assign rd_ent = ENT_W'(32'(read_row_addr) * HALF + 32'(read_col_addr));

    assign input_data_even_even = rd_ok ? bank[0][rd_ent] : '0;
    assign input_data_even_odd  = rd_ok ? bank[1][rd_ent] : '0;
    assign input_data_odd_even  = rd_ok ? bank[2][rd_ent] : '0;
    assign input_data_odd_odd   = rd_ok ? bank[3][rd_ent] : '0;

    assign pixel_store_done = done_q;
    assign state_dbg        = state_q;

endmodule
